framebuffer_writer: RTL
=======================

Name: framebuffer_writer

Overview:
- Write-side counterpart of the VGA framebuffer read path.
- Accepts a raster-ordered stream of 4-bit grayscale pixels from the ray-marcher core over a valid/ready handshake.
- Writes each pixel into framebuffer BRAM (port A) at address y*DISPLAY_WIDTH + x, framing one complete image per frame_start_in request.
- Signals frame completion so the top level can swap or present the buffer.

Parameters:
- WIDTH, `DISPLAY_WIDTH (160): pixels per framebuffer row.
- HEIGHT, `DISPLAY_HEIGHT (120): rows per frame.
- ADDR_W, `ADDR_BITS (15): BRAM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- clk_in  input  1  compute/BRAM write clock
- rst_in  input  1  synchronous active-high reset
- frame_start_in  input  1  single-cycle request to begin (or restart) a frame
- pixel_in  input  4  grayscale pixel value
- pixel_valid_in  input  1  pixel_in valid
- pixel_ready_out  output  1  writer can accept a pixel this cycle
- write_addr_out  output  ADDR_W  BRAM write address
- write_data_out  output  4  BRAM write data
- write_enable_out  output  1  BRAM write strobe
- busy_out  output  1  frame in progress
- frame_done_out  output  1  one-cycle pulse when the last pixel of a frame is written
- frame_count_out  output  16  completed-frame counter, wraps at 2^16

Behaviour:
- Interface: one clock (clk_in); reset rst_in is synchronous and active-high.
- Reset values: state IDLE; x=y=0; addr=0; all outputs 0, including pixel_ready_out, write_enable_out, frame_done_out, busy_out, frame_count_out, write_addr_out and write_data_out.

States:
- IDLE:
  - pixel_ready_out=0; pixel_valid_in is ignored.
  - frame_start_in=1 -> WRITE, with x=y=addr=0.
- WRITE:
  - pixel_ready_out=1 and busy_out=1; both are decoded from state.
  - Accept occurs when pixel_valid_in & pixel_ready_out.
- DONE:
  - Lasts exactly one cycle; pixel_ready_out=0, busy_out=0.
  - Next state is IDLE, or WRITE (counters zeroed) if frame_start_in=1 in that cycle.

Write timing:
- An accept in cycle N produces write_enable_out=1 in cycle N+1, with write_addr_out = addr at acceptance and write_data_out = pixel_in. Latency is exactly 1 cycle.
- write_enable_out=0 in every cycle with no accept in the preceding cycle.
- Back-to-back accepts give one write per cycle (full throughput); valid gaps simply insert idle cycles.

Counters (per accept):
- addr increments by 1; no multiplier is used in the write path.
- x increments by 1; at x==WIDTH-1, x wraps to 0 and y increments.
- Accepting x==WIDTH-1, y==HEIGHT-1 moves to DONE.

Frame completion:
- frame_done_out=1 in the same cycle as the final write_enable_out (the DONE cycle).
- frame_count_out increments by 1 in that same cycle.

Restart and abort:
- frame_start_in while in WRITE aborts the frame: counters reset to 0 and the state remains WRITE.
- A pixel offered in the restart cycle is dropped (no write issued).
- No frame_done_out pulse and no frame_count increment for an aborted frame.
- frame_start_in in IDLE and WRITE on the same cycle as rst_in: reset wins.
- rst_in mid-frame returns everything to reset values next cycle; a pending write from the previous cycle's accept is suppressed (write_enable_out=0).

Width rules:
- addr never exceeds WIDTH*HEIGHT-1.
- x is $clog2(WIDTH) bits; y is $clog2(HEIGHT) bits.

Decomposition:
- Shared package / types.sv: `DISPLAY_WIDTH, `DISPLAY_HEIGHT, `ADDR_BITS, and the pixel width (4), shared with the VGA read path so both ends agree on layout.
- State enum (IDLE/WRITE/DONE) is local to the module.
- One natural sub-module, raster_counter:
  - Inputs: step, clear.
  - Outputs: x, y, addr, last (x==WIDTH-1 && y==HEIGHT-1).
  - Handles wrap; reusable by other raster producers.

Test Plan (WIDTH=4, HEIGHT=3 unless noted):
- Reset: hold rst_in 3 cycles with pixel_valid_in=1 -> all outputs 0, no write_enable_out; frame_start_in afterwards -> pixel_ready_out=1 next cycle.
- Full frame, continuous valid: frame_start_in, then 12 pixels with values 0..11 -> 12 consecutive writes with addr 0..11 and data 0..11, each 1 cycle after its accept; frame_done_out=1 only with the addr-11 write; frame_count_out=1; pixel_ready_out=0 after the last accept.
- Bubbles: valid toggled 1,0,0,1,... -> writes only in cycles after accepts, addresses still contiguous; row wrap correct (addr 4 = x0,y1).
- Abort: frame_start_in after 5 accepts, with a pixel offered in that cycle -> that pixel is not written; next write is addr 0; no frame_done_out; frame_count_out unchanged.
- Back-to-back frames: frame_start_in asserted in the DONE cycle -> WRITE follows with no IDLE cycle; second frame addresses restart at 0; frame_count_out=2 at end.
- Reset mid-frame: rst_in the cycle after an accept -> no write_enable_out in the following cycle; state IDLE; pixel_ready_out=0.

Source files
------------

// File: rtl/framebuffer_writer_pkg.sv
// ============================================================================
// framebuffer_writer_pkg : framebuffer geometry and pixel format shared by the
//                          write path and the VGA read path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package framebuffer_writer_pkg;

    localparam int DISPLAY_WIDTH  = 160;
    localparam int DISPLAY_HEIGHT = 120;
    localparam int ADDR_BITS      = 15;
    localparam int PIXEL_W        = 4;

    typedef logic [PIXEL_W-1:0] pixel_t;

    // Counter width that still represents a value of n-1 (at least one bit).
    function automatic int coord_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/framebuffer_writer_if.sv
// ============================================================================
// framebuffer_writer_if : pixel-stream handshake, frame control and BRAM
//                         port-A write bus of the framebuffer writer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface framebuffer_writer_if
    import framebuffer_writer_pkg::*;
#(
    parameter int ADDR_W = ADDR_BITS
);
    logic              frame_start_in;
    pixel_t            pixel_in;
    logic              pixel_valid_in;
    logic              pixel_ready_out;
    logic [ADDR_W-1:0] write_addr_out;
    pixel_t            write_data_out;
    logic              write_enable_out;
    logic              busy_out;
    logic              frame_done_out;
    logic [15:0]       frame_count_out;

    // Producer / system side.
    modport master (
        output frame_start_in, pixel_in, pixel_valid_in,
        input  pixel_ready_out, write_addr_out, write_data_out,
        input  write_enable_out, busy_out, frame_done_out, frame_count_out
    );

    // Writer side.
    modport slave (
        input  frame_start_in, pixel_in, pixel_valid_in,
        output pixel_ready_out, write_addr_out, write_data_out,
        output write_enable_out, busy_out, frame_done_out, frame_count_out
    );
endinterface

`default_nettype wire

// File: rtl/framebuffer_writer_raster_counter.sv
// ============================================================================
// raster_counter : x/y raster position with a running linear address, so the
//                  address is y*WIDTH+x without a multiplier.
// Revision: 1.0
// ============================================================================
`default_nettype none

module raster_counter
    import framebuffer_writer_pkg::*;
#(
    parameter int WIDTH  = DISPLAY_WIDTH,
    parameter int HEIGHT = DISPLAY_HEIGHT,
    parameter int ADDR_W = ADDR_BITS,
    parameter int X_W    = coord_bits(WIDTH),
    parameter int Y_W    = coord_bits(HEIGHT)
) (
    input  wire logic              clk_in,
    input  wire logic              rst_in,
    input  wire logic              step_i,
    input  wire logic              clear_i,
    output logic [X_W-1:0]         x_o,
    output logic [Y_W-1:0]         y_o,
    output logic [ADDR_W-1:0]      addr_o,
    output logic                   last_o
);
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [ADDR_W-1:0] addr_q;
    logic              w_x_end;

    assign w_x_end = (x_q == X_W'(WIDTH - 1));
    assign last_o  = w_x_end && (y_q == Y_W'(HEIGHT - 1));
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign addr_o  = addr_q;

    always_ff @(posedge clk_in) begin
        if (rst_in || clear_i) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else if (step_i) begin
            // Stepping past the final pixel rewinds so addr stays in range.
            if (last_o) begin
                x_q    <= '0;
                y_q    <= '0;
                addr_q <= '0;
            end else begin
                addr_q <= addr_q + ADDR_W'(1);
                if (w_x_end) begin
                    x_q <= '0;
                    y_q <= y_q + Y_W'(1);
                end else begin
                    x_q <= x_q + X_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/framebuffer_writer.sv
// ============================================================================
// framebuffer_writer : writes one raster-ordered grayscale frame per start
//                      request into framebuffer BRAM port A.
// Revision: 1.0
// ============================================================================
`default_nettype none

module framebuffer_writer
    import framebuffer_writer_pkg::*;
#(
    parameter int WIDTH  = DISPLAY_WIDTH,
    parameter int HEIGHT = DISPLAY_HEIGHT,
    parameter int ADDR_W = ADDR_BITS
) (
    input  wire logic             clk_in,
    input  wire logic             rst_in,
    framebuffer_writer_if.slave   fb_if
);
    localparam int X_W = coord_bits(WIDTH);
    localparam int Y_W = coord_bits(HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic              we_q;
    logic              done_q;
    logic [ADDR_W-1:0] waddr_q;
    pixel_t            wdata_q;
    logic [15:0]       count_q;
    logic [15:0]       count_d;

    logic              w_accept;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;
    logic [X_W-1:0]    w_x;
    logic [Y_W-1:0]    w_y;
    logic              w_unused_xy;

    // A start request in WRITE restarts the frame and drops the offered pixel.
    assign w_accept = (state_q == S_WRITE) && fb_if.pixel_valid_in && !fb_if.frame_start_in;
    assign count_d  = count_q + 16'd1;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_raster (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .step_i  (w_accept),
        .clear_i (fb_if.frame_start_in),
        .x_o     (w_x),
        .y_o     (w_y),
        .addr_o  (w_addr),
        .last_o  (w_last)
    );

    assign w_unused_xy = ^{w_x, w_y};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            count_q <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fb_if.frame_start_in) state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (w_accept) begin
                        we_q    <= 1'b1;
                        waddr_q <= w_addr;
                        wdata_q <= fb_if.pixel_in;
                        if (w_last) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            count_q <= count_d;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= fb_if.frame_start_in ? S_WRITE : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fb_if.pixel_ready_out  = (state_q == S_WRITE);
    assign fb_if.busy_out         = (state_q == S_WRITE);
    assign fb_if.write_enable_out = we_q;
    assign fb_if.write_addr_out   = waddr_q;
    assign fb_if.write_data_out   = wdata_q;
    assign fb_if.frame_done_out   = done_q;
    assign fb_if.frame_count_out  = count_q;

endmodule

`default_nettype wire
